sda_to_par: RTL and testbench

Serial-to-parallel receiver for the two-wire scl/sda link driven by the team's 4-bit parallel-to-serial transmitter. It detects a start condition (sda falling while scl is high), then shifts in data bits MSB-first on scl rising edges, and closes the frame on a stop condition (sda rising while scl is high). Each good frame produces a parallel word, a one-cycle valid strobe and a latched one-hot decode. The block sits at the far end of the link, in the sclk domain of the consuming logic.

---
 rtl/sda_pkg.sv | 21 ++
 rtl/sda_sync.sv | 40 ++++
 rtl/sda_to_par.sv | 143 ++++++++++++++
 tb/tb_sda_to_par.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/sda_pkg.sv
// Shared definitions for the scl/sda serial link (receiver and transmitter).
// Latency: n/a (types, constants and helpers only).
// Backpressure: n/a.
package sda_pkg;

   // Data bits per frame; the transmitter imports this same value.
   localparam int NBITS_DEF = 4;

   // Receiver frame states.
   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_SHIFT     = 2'd1,
      ST_WAIT_STOP = 2'd2
   } state_t;

   // Bits needed to count 0..nbits without wrapping.
   function automatic int cnt_width(input int nbits);
      return $clog2(nbits + 1);
   endfunction

endpackage

// File: rtl/sda_sync.sv
// Purpose: multi-flop synchronizer plus history flop for one async line, with edge strobes.
// Latency: STAGES sclk edges to the synchronized level; strobes valid in the same cycle as the level.
// Backpressure: none; free-running.
//
// Ports:
//   sclk  - receiver clock
//   rst   - async active-low reset; all flops reset to 1 (idle bus level)
//   din   - asynchronous input line
//   lvl   - synchronized level
//   rise  - one-cycle strobe on a synchronized 0->1
//   fall  - one-cycle strobe on a synchronized 1->0
module sda_sync #(
   parameter int STAGES = 2
) (
   input  logic sclk,
   input  logic rst,
   input  logic din,
   output logic lvl,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] sync;
   logic              hist;

   always_ff @(posedge sclk or negedge rst) begin
      if (!rst) begin
         sync <= '1;
         hist <= 1'b1;
      end else begin
         sync <= {sync[STAGES-2:0], din};
         hist <= sync[STAGES-1];
      end
   end

   assign lvl  = sync[STAGES-1];
   assign rise = lvl & ~hist;
   assign fall = ~lvl & hist;

endmodule

// File: rtl/sda_to_par.sv
// Purpose: scl/sda frame receiver; start, NBITS MSB-first bits, stop -> parallel word + one-hot decode.
// Latency: outputs update 2 sclk edges after the edge that first samples the stop/offending line change.
// Backpressure: none; valid is a one-cycle strobe and data/outhigh hold until the next good frame.
//
// Ports:
//   sclk, rst  - receiver clock, async active-low reset
//   scl, sda   - asynchronous serial link inputs
//   data       - last good word (NBITS, legal 1..6)
//   valid      - one-cycle strobe when data/outhigh update
//   outhigh    - one-hot decode of data, all-zero until the first good frame
//   frame_err  - one-cycle strobe on a malformed frame
//   busy       - high from start detect until frame end or abort
module sda_to_par
   import sda_pkg::*;
#(
   parameter int NBITS       = NBITS_DEF,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  sclk,
   input  logic                  rst,
   input  logic                  scl,
   input  logic                  sda,
   output logic [NBITS-1:0]      data,
   output logic                  valid,
   output logic [(1<<NBITS)-1:0] outhigh,
   output logic                  frame_err,
   output logic                  busy
);

   localparam int CW = cnt_width(NBITS);
   localparam int OW = 1 << NBITS;

   // Synchronized line levels and edge strobes.
   logic scl_lvl, scl_rise, scl_fall_unused;
   logic sda_lvl, sda_rise, sda_fall;

   sda_sync #(.STAGES(SYNC_STAGES)) u_scl_sync (
      .sclk (sclk),
      .rst  (rst),
      .din  (scl),
      .lvl  (scl_lvl),
      .rise (scl_rise),
      .fall (scl_fall_unused)
   );

   sda_sync #(.STAGES(SYNC_STAGES)) u_sda_sync (
      .sclk (sclk),
      .rst  (rst),
      .din  (sda),
      .lvl  (sda_lvl),
      .rise (sda_rise),
      .fall (sda_fall)
   );

   // Both lines go through identical synchronizers, so an sda edge that the
   // transmitter makes together with an scl rise is seen here in the same
   // cycle, qualified by the new scl level.
   logic start_ev, stop_ev;
   assign start_ev = sda_fall & scl_lvl;
   assign stop_ev  = sda_rise & scl_lvl;

   state_t           state, state_nxt;
   logic [CW-1:0]    cnt, cnt_nxt;
   logic [NBITS-1:0] shreg, shreg_nxt;
   logic             load, err;

   always_ff @(posedge sclk or negedge rst) begin
      if (!rst) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         shreg     <= '0;
         data      <= '0;
         outhigh   <= '0;
         valid     <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         shreg     <= shreg_nxt;
         valid     <= load;
         frame_err <= err;
         if (load) begin
            data    <= shreg;
            outhigh <= OW'(1) << shreg;
         end
      end
   end

   // start/stop take priority over scl_rise in every state.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      shreg_nxt = shreg;
      load      = 1'b0;
      err       = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start_ev) begin
               state_nxt = ST_SHIFT;
               cnt_nxt   = '0;
               shreg_nxt = '0;
            end
         end
         ST_SHIFT: begin
            if (start_ev) begin
               // Repeated start: restart the frame silently.
               cnt_nxt   = '0;
               shreg_nxt = '0;
            end else if (stop_ev) begin
               err       = 1'b1;
               state_nxt = ST_IDLE;
            end else if (scl_rise) begin
               shreg_nxt = (shreg << 1) | NBITS'(sda_lvl);
               cnt_nxt   = cnt + CW'(1);
               if (cnt == CW'(NBITS - 1)) begin
                  state_nxt = ST_WAIT_STOP;
               end
            end
         end
         ST_WAIT_STOP: begin
            if (start_ev) begin
               // Completed word is dropped in favour of the new frame.
               err       = 1'b1;
               state_nxt = ST_SHIFT;
               cnt_nxt   = '0;
               shreg_nxt = '0;
            end else if (stop_ev) begin
               load      = 1'b1;
               state_nxt = ST_IDLE;
            end else if (scl_rise) begin
               err       = 1'b1;
               state_nxt = ST_IDLE;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_sda_to_par.sv
module tb_sda_to_par;

   logic        sclk = 1'b0;
   logic        rst  = 1'b0;
   logic        scl  = 1'b1;
   logic        sda  = 1'b1;
   logic [3:0]  data;
   logic        valid;
   logic [15:0] outhigh;
   logic        frame_err;
   logic        busy;

   int checks = 0;
   int errors = 0;

   // Pulse bookkeeping filled at every falling sclk edge.
   int nv = 0, ne = 0, vrun = 0, erun = 0, vmax = 0, emax = 0, both = 0;
   logic [3:0]  vdat [0:7];
   logic [15:0] voh  [0:7];

   sda_to_par #(.NBITS(4), .SYNC_STAGES(2)) dut (
      .sclk      (sclk),
      .rst       (rst),
      .scl       (scl),
      .sda       (sda),
      .data      (data),
      .valid     (valid),
      .outhigh   (outhigh),
      .frame_err (frame_err),
      .busy      (busy)
   );

   always #5 sclk = ~sclk;

   always @(negedge sclk) begin
      if (valid === 1'b1) begin
         if (nv < 8) begin
            vdat[nv] = data;
            voh[nv]  = outhigh;
         end
         nv++;
         vrun++;
         if (vrun > vmax) vmax = vrun;
      end else begin
         vrun = 0;
      end
      if (frame_err === 1'b1) begin
         ne++;
         erun++;
         if (erun > emax) emax = erun;
      end else begin
         erun = 0;
      end
      if (valid === 1'b1 && frame_err === 1'b1) both++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance n sclk cycles, landing 2 ns after a rising edge.
   task automatic cyc(input int n);
      repeat (n) @(posedge sclk);
      #2;
   endtask

   task automatic start_c(input int h);
      sda = 1'b0;
      cyc(h);
      scl = 1'b0;
   endtask

   task automatic send_bit(input logic b, input int h);
      sda = b;
      cyc(h);
      scl = 1'b1;
      cyc(h);
      scl = 1'b0;
   endtask

   // sda rises together with scl, so the stop and the scl rise decode in one cycle.
   task automatic stop_c(input int h);
      sda = 1'b0;
      cyc(h);
      scl = 1'b1;
      sda = 1'b1;
      cyc(h);
   endtask

   task automatic frame(input logic [3:0] w, input int h);
      start_c(h);
      for (int i = 3; i >= 0; i--) send_bit(w[i], h);
      stop_c(h);
   endtask

   initial begin
      // Reset state
      cyc(3);
      chk("rst_data", data, 4'h0);
      chk("rst_outhigh", outhigh, 16'h0000);
      chk("rst_valid", valid, 1'b0);
      chk("rst_ferr", frame_err, 1'b0);
      chk("rst_busy", busy, 1'b0);
      rst = 1'b1;
      cyc(4);

      // Good frame 4'b1011 with exact latency checks
      sda = 1'b0;
      cyc(2);
      chk("busy_before_k2", busy, 1'b0);
      cyc(1);
      chk("busy_after_k2", busy, 1'b1);
      cyc(1);
      scl = 1'b0;
      send_bit(1'b1, 4);
      send_bit(1'b0, 4);
      send_bit(1'b1, 4);
      send_bit(1'b1, 4);
      chk("busy_mid_frame", busy, 1'b1);
      sda = 1'b0;
      cyc(4);
      scl = 1'b1;
      sda = 1'b1;
      cyc(2);
      chk("valid_before_k2", valid, 1'b0);
      cyc(1);
      chk("valid_at_k2", valid, 1'b1);
      chk("good_data", data, 4'hB);
      chk("good_outhigh", outhigh, 16'h0800);
      chk("busy_fall", busy, 1'b0);
      cyc(1);
      chk("valid_one_cycle", valid, 1'b0);
      cyc(4);
      chk("good_nvalid", nv, 1);
      chk("good_nerr", ne, 0);

      // Short frame: 2 bits then stop
      start_c(4);
      send_bit(1'b1, 4);
      send_bit(1'b0, 4);
      stop_c(4);
      cyc(4);
      chk("short_nerr", ne, 1);
      chk("short_nvalid", nv, 1);
      chk("short_data", data, 4'hB);
      chk("short_outhigh", outhigh, 16'h0800);
      chk("short_busy", busy, 1'b0);

      // Long frame: 5 bits, then a stop that must be ignored
      start_c(4);
      send_bit(1'b1, 4);
      send_bit(1'b0, 4);
      send_bit(1'b1, 4);
      send_bit(1'b0, 4);
      send_bit(1'b1, 4);
      chk("long_nerr", ne, 2);
      chk("long_busy", busy, 1'b0);
      stop_c(4);
      cyc(4);
      chk("long_stop_nerr", ne, 2);
      chk("long_stop_nvalid", nv, 1);
      chk("long_data", data, 4'hB);

      // Repeated start after 2 bits, then 4'h3
      start_c(4);
      send_bit(1'b1, 4);
      send_bit(1'b1, 4);
      sda = 1'b1;
      cyc(4);
      scl = 1'b1;
      cyc(4);
      sda = 1'b0;
      cyc(4);
      scl = 1'b0;
      send_bit(1'b0, 4);
      send_bit(1'b0, 4);
      send_bit(1'b1, 4);
      send_bit(1'b1, 4);
      stop_c(4);
      cyc(4);
      chk("rstart_nerr", ne, 2);
      chk("rstart_nvalid", nv, 2);
      chk("rstart_data", data, 4'h3);
      chk("rstart_outhigh", outhigh, 16'h0008);

      // Reset mid-frame (4'hF after 2 bits), then good frame 4'h6
      start_c(4);
      send_bit(1'b1, 4);
      send_bit(1'b1, 4);
      rst = 1'b0;
      #1;
      chk("mrst_busy", busy, 1'b0);
      chk("mrst_data", data, 4'h0);
      chk("mrst_outhigh", outhigh, 16'h0000);
      cyc(2);
      chk("mrst_valid", valid, 1'b0);
      chk("mrst_ferr", frame_err, 1'b0);
      scl = 1'b1;
      sda = 1'b1;
      cyc(2);
      rst = 1'b1;
      cyc(6);
      chk("post_rst_busy", busy, 1'b0);
      frame(4'h6, 4);
      cyc(4);
      chk("post_rst_nvalid", nv, 3);
      chk("post_rst_data", data, 4'h6);
      chk("post_rst_outhigh", outhigh, 16'h0040);
      chk("post_rst_nerr", ne, 2);

      // Back-to-back 4'h0 and 4'hF at the 4x clock ratio
      frame(4'h0, 2);
      frame(4'hF, 2);
      cyc(6);
      chk("b2b_nvalid", nv, 5);
      chk("b2b_nerr", ne, 2);
      chk("b2b_data0", vdat[3], 4'h0);
      chk("b2b_oh0", voh[3], 16'h0001);
      chk("b2b_data1", vdat[4], 4'hF);
      chk("b2b_oh1", voh[4], 16'h8000);
      chk("b2b_data", data, 4'hF);

      // Pulse shape over the whole run
      chk("valid_max_width", vmax, 1);
      chk("ferr_max_width", emax, 1);
      chk("valid_ferr_overlap", both, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
